// File: rtl/fetch_unit_pkg.sv
// Core-wide fetch definitions: reset/bubble defaults and the IF/ID register layout shared with decode.
package fetch_unit_pkg;

    localparam int          XLEN          = 32;
    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch performance counters: delivered instructions and stall/flush bubbles, both free-running and wrapping.
module fetch_perf_cnt #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture_i,
    output logic [DATA_WIDTH-1:0] fetch_cnt_o,
    output logic [DATA_WIDTH-1:0] bubble_cnt_o
);

    logic [DATA_WIDTH-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [DATA_WIDTH-1:0] bubble_cnt_q, bubble_cnt_d;

    // Every non-reset edge is either a capture or a bubble (flush or stall).
    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (capture_i) fetch_cnt_d  = fetch_cnt_q + DATA_WIDTH'(1);
        else           bubble_cnt_d = bubble_cnt_q + DATA_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_cnt_o  = fetch_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: PC register, next-PC select and IF/ID register.
// Optional counters enabled by defining FETCH_PERF_CNT_EN; otherwise counter ports read 0.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DEF_NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_f,
    input  logic                  flush_d,
    input  logic                  redirect_en,
    input  logic [DATA_WIDTH-1:0] redirect_target,
    output logic [DATA_WIDTH-1:0] pc_f,
    input  logic [DATA_WIDTH-1:0] instr_f,
    output logic [DATA_WIDTH-1:0] instr_d,
    output logic [DATA_WIDTH-1:0] pc_d,
    output logic [DATA_WIDTH-1:0] pc_plus4_d,
    output logic                  valid_d,
    output logic [DATA_WIDTH-1:0] fetch_cnt,
    output logic [DATA_WIDTH-1:0] bubble_cnt
);

    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};

    logic [DATA_WIDTH-1:0] pc_f_q, pc_f_d;
    logic [DATA_WIDTH-1:0] pc_plus4;
    ifid_t                 ifid_q, ifid_d;

    assign pc_plus4 = pc_f_q + DATA_WIDTH'(4);

    always_comb begin
        pc_f_d = pc_plus4;
        if (redirect_en)  pc_f_d = align_word(redirect_target);
        else if (stall_f) pc_f_d = pc_f_q;
    end

    // A redirect discards the wrong-path word even when decode is stalled.
    always_comb begin
        ifid_d = ifid_q;
        if (redirect_en || flush_d) ifid_d = IFID_BUBBLE;
        else if (!stall_f)          ifid_d = '{instr: instr_f, pc: pc_f_q, pc_plus4: pc_plus4, valid: 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_f_q <= RESET_PC;
            ifid_q <= IFID_BUBBLE;
        end else begin
            pc_f_q <= pc_f_d;
            ifid_q <= ifid_d;
        end
    end

    assign pc_f       = pc_f_q;
    assign instr_d    = ifid_q.instr;
    assign pc_d       = ifid_q.pc;
    assign pc_plus4_d = ifid_q.pc_plus4;
    assign valid_d    = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
    logic capture;
    assign capture = !(redirect_en || flush_d || stall_f);

    fetch_perf_cnt #(.DATA_WIDTH(DATA_WIDTH)) u_perf_cnt (
        .clk          (clk),
        .rst          (rst),
        .capture_i    (capture),
        .fetch_cnt_o  (fetch_cnt),
        .bubble_cnt_o (bubble_cnt)
    );
`else
    assign fetch_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential fetch, stall, redirect, redirect-under-stall, wrap and flush.
module tb_fetch_unit;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_f = 1'b0, flush_d = 1'b0, redirect_en = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] pc_f, instr_f, instr_d, pc_d, pc_plus4_d, fetch_cnt, bubble_cnt;
    logic        valid_d;

    int passed = 0;
    int total  = 0;

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall_f(stall_f), .flush_d(flush_d),
        .redirect_en(redirect_en), .redirect_target(redirect_target),
        .pc_f(pc_f), .instr_f(instr_f), .instr_d(instr_d), .pc_d(pc_d),
        .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
        .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    // Instruction memory: A0..A3 at words 0..3, address-tagged words elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'h10) return 32'hA0 + (a >> 2);
        return 32'hC000_0000 ^ a;
    endfunction

    always_comb instr_f = mem_word(pc_f);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall_f = 0; flush_d = 0; redirect_en = 0; redirect_target = '0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(); step();
        total++; if (pc_f !== 32'h8) $display("FAIL pre_reset_pc got=%h exp=%h", pc_f, 32'h8); else passed++;
        rst = 1'b1;
        redirect_en = 1'b1; redirect_target = 32'h80; stall_f = 1'b1;
        #1;
        total++; if (pc_f !== 32'h0) $display("FAIL async_reset_pc got=%h exp=%h", pc_f, 32'h0); else passed++;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (pc_f !== 32'h0 || valid_d !== 1'b0 || instr_d !== 32'h13)
                $display("FAIL in_reset[%0d] pc=%h valid=%b instr=%h exp pc=0 valid=0 instr=13", i, pc_f, valid_d, instr_d);
            else passed++;
        end
        total++; if (fetch_cnt !== 32'h0 || bubble_cnt !== 32'h0)
            $display("FAIL reset_cnt got=%h/%h exp=0/0", fetch_cnt, bubble_cnt); else passed++;
        redirect_en = 1'b0; stall_f = 1'b0;
        rst = 1'b0;
        #1;
        total++; if (pc_f !== 32'h0) $display("FAIL release_pc got=%h exp=%h", pc_f, 32'h0); else passed++;
        step();
        total++; if (pc_f !== 32'h4 || instr_d !== 32'hA0)
            $display("FAIL first_capture pc=%h instr=%h exp pc=4 instr=a0", pc_f, instr_d); else passed++;
        step();
        total++; if (pc_f !== 32'h8) $display("FAIL second_step_pc got=%h exp=%h", pc_f, 32'h8); else passed++;
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (instr_d !== 32'hA0 + i || pc_d !== 4 * i || pc_plus4_d !== 4 * i + 4 || valid_d !== 1'b1 || pc_f !== 4 * i + 4)
                $display("FAIL seq[%0d] instr=%h pc_d=%h pc4=%h v=%b pc_f=%h exp instr=%h pc_d=%h pc4=%h v=1 pc_f=%h",
                         i, instr_d, pc_d, pc_plus4_d, valid_d, pc_f, 32'hA0 + i, 4 * i, 4 * i + 4, 4 * i + 4);
            else passed++;
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(); step();
        stall_f = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (pc_f !== 32'h8 || instr_d !== 32'hA1 || pc_d !== 32'h4 || valid_d !== 1'b1)
                $display("FAIL stall[%0d] pc_f=%h instr=%h pc_d=%h v=%b exp pc_f=8 instr=a1 pc_d=4 v=1", i, pc_f, instr_d, pc_d, valid_d);
            else passed++;
        end
        stall_f = 1'b0;
        step();
        total++; if (instr_d !== 32'hA2 || pc_d !== 32'h8 || pc_f !== 32'hC)
            $display("FAIL post_stall instr=%h pc_d=%h pc_f=%h exp a2/8/c", instr_d, pc_d, pc_f); else passed++;
        step();
        total++; if (instr_d !== 32'hA3 || pc_d !== 32'hC)
            $display("FAIL post_stall2 instr=%h pc_d=%h exp a3/c", instr_d, pc_d); else passed++;
        total++; if (fetch_cnt !== (PERF ? 32'd4 : 32'd0) || bubble_cnt !== (PERF ? 32'd2 : 32'd0))
            $display("FAIL stall_cnt got=%0d/%0d exp=%0d/%0d", fetch_cnt, bubble_cnt, PERF ? 4 : 0, PERF ? 2 : 0);
        else passed++;
    endtask

    task automatic test_redirect();
        do_reset();
        step(); step(); step();
        total++; if (pc_f !== 32'hC) $display("FAIL redir_setup pc_f=%h exp=c", pc_f); else passed++;
        redirect_en = 1'b1; redirect_target = 32'h43;
        step();
        redirect_en = 1'b0;
        total++; if (pc_f !== 32'h40 || valid_d !== 1'b0 || instr_d !== 32'h13 || pc_d !== 32'h0)
            $display("FAIL redir_n1 pc_f=%h v=%b instr=%h pc_d=%h exp 40/0/13/0", pc_f, valid_d, instr_d, pc_d); else passed++;
        step();
        total++; if (instr_d !== 32'hC000_0040 || pc_d !== 32'h40 || pc_plus4_d !== 32'h44 || valid_d !== 1'b1 || pc_f !== 32'h44)
            $display("FAIL redir_n2 instr=%h pc_d=%h pc4=%h v=%b pc_f=%h exp c0000040/40/44/1/44", instr_d, pc_d, pc_plus4_d, valid_d, pc_f);
        else passed++;
    endtask

    task automatic test_redirect_stall();
        do_reset();
        step();
        stall_f = 1'b1; redirect_en = 1'b1; redirect_target = 32'h20;
        step();
        stall_f = 1'b0; redirect_en = 1'b0;
        total++; if (pc_f !== 32'h20 || valid_d !== 1'b0)
            $display("FAIL redir_stall pc_f=%h v=%b exp 20/0", pc_f, valid_d); else passed++;
        total++; if (fetch_cnt !== (PERF ? 32'd1 : 32'd0) || bubble_cnt !== (PERF ? 32'd1 : 32'd0))
            $display("FAIL redir_stall_cnt got=%0d/%0d exp=%0d/%0d", fetch_cnt, bubble_cnt, PERF ? 1 : 0, PERF ? 1 : 0);
        else passed++;
        step();
        total++; if (instr_d !== 32'hC000_0020 || pc_d !== 32'h20)
            $display("FAIL redir_stall_n2 instr=%h pc_d=%h exp c0000020/20", instr_d, pc_d); else passed++;
    endtask

    task automatic test_wrap_flush();
        do_reset();
        redirect_en = 1'b1; redirect_target = 32'hFFFF_FFFF;
        step();
        redirect_en = 1'b0;
        total++; if (pc_f !== 32'hFFFF_FFFC) $display("FAIL wrap_align pc_f=%h exp fffffffc", pc_f); else passed++;
        step();
        total++; if (pc_f !== 32'h0 || pc_plus4_d !== 32'h0 || pc_d !== 32'hFFFF_FFFC || instr_d !== 32'h3FFF_FFFC)
            $display("FAIL wrap pc_f=%h pc4=%h pc_d=%h instr=%h exp 0/0/fffffffc/3ffffffc", pc_f, pc_plus4_d, pc_d, instr_d);
        else passed++;
        flush_d = 1'b1;
        step();
        flush_d = 1'b0;
        total++; if (pc_f !== 32'h4 || valid_d !== 1'b0 || instr_d !== 32'h13 || pc_d !== 32'h0)
            $display("FAIL flush pc_f=%h v=%b instr=%h pc_d=%h exp 4/0/13/0", pc_f, valid_d, instr_d, pc_d); else passed++;
        step();
        total++; if (instr_d !== 32'hA1 || valid_d !== 1'b1 || pc_f !== 32'h8)
            $display("FAIL post_flush instr=%h v=%b pc_f=%h exp a1/1/8", instr_d, valid_d, pc_f); else passed++;
        flush_d = 1'b1; stall_f = 1'b1;
        step();
        flush_d = 1'b0; stall_f = 1'b0;
        total++; if (pc_f !== 32'h8 || valid_d !== 1'b0 || instr_d !== 32'h13)
            $display("FAIL flush_stall pc_f=%h v=%b instr=%h exp 8/0/13", pc_f, valid_d, instr_d); else passed++;
        total++; if (fetch_cnt !== (PERF ? 32'd2 : 32'd0) || bubble_cnt !== (PERF ? 32'd3 : 32'd0))
            $display("FAIL wrap_cnt got=%0d/%0d exp=%0d/%0d", fetch_cnt, bubble_cnt, PERF ? 2 : 0, PERF ? 3 : 0);
        else passed++;
    endtask

    initial begin
        step();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap_flush();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined RV32I core. It owns the program counter and drives it combinationally into the asynchronous instruction memory. It registers the returned word, together with its PC and PC+4, into the IF/ID pipeline register consumed by decode. It also applies the hazard unit's stall and flush requests and the execute stage's branch/jump redirects.

## Interface
Parameters:
- DATA_WIDTH, 32: width of PC, instruction and counters.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013: `addi x0,x0,0`, inserted into IF/ID on flush and reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall_f  in  1  hold PC and IF/ID (load-use hazard).
- flush_d  in  1  replace IF/ID contents with a bubble.
- redirect_en  in  1  taken branch/jump resolved in execute.
- redirect_target  in  DATA_WIDTH  new fetch address.
- pc_f  out  DATA_WIDTH  current fetch address to instruction memory.
- instr_f  in  DATA_WIDTH  word returned by instruction memory for pc_f, same cycle.
- instr_d  out  DATA_WIDTH  IF/ID instruction.
- pc_d  out  DATA_WIDTH  IF/ID PC.
- pc_plus4_d  out  DATA_WIDTH  IF/ID PC+4.
- valid_d  out  1  IF/ID holds a real instruction.
- fetch_cnt  out  DATA_WIDTH  instructions delivered to decode (see Configuration).
- bubble_cnt  out  DATA_WIDTH  stall/flush cycles (see Configuration).

## Operation
- **Next-PC priority, evaluated each cycle:**
  - If redirect_en: `{redirect_target[31:2],2'b00}`.
  - Else if stall_f: pc_f unchanged.
  - Else: pc_f+4.
- **PC alignment:** the low two bits of redirect_target are always discarded, so pc_f[1:0] is always 00.
- **IF/ID update priority:**
  - **Flush**, when flush_d or redirect_en: instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0. redirect_en flushes internally; the hazard unit need not also assert flush_d.
  - **Stall**, when stall_f: all IF/ID fields hold.
  - **Capture**: instr_d=instr_f, pc_d=pc_f, pc_plus4_d=pc_f+4, valid_d=1.
- **Simultaneous redirect_en and stall_f:** the redirect wins. PC loads the target and IF/ID flushes. The stalled instruction is on the wrong path and is discarded.
- **Simultaneous flush_d and stall_f without a redirect:** PC holds, IF/ID flushes.
- **Arithmetic:** PC+4 wraps modulo 2^DATA_WIDTH. 32'hFFFF_FFFC+4 gives 0, with no flag.
- **Reset values:**
  - pc_f=RESET_PC.
  - instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0.
  - Counters 0.
- **Reset asserted mid-operation:** all state is forced to reset values immediately, regardless of stall/redirect. The first capture occurs on the first rising edge after rst deasserts.

## Timing
- **Fetch path:** pc_f is a register output. instr_f is combinational from pc_f (memory read is asynchronous).
- **Fetch-to-decode latency:** the word at pc_f appears on instr_d after 1 rising edge.
- **Redirect, in cycle N:** redirect_en high in cycle N puts the target on pc_f in cycle N+1 and gives valid_d=0 in cycle N+1. The target instruction reaches instr_d in N+2, giving a 1-bubble taken-branch penalty in this stage.
- **Stall duration:** a stall of K cycles holds pc_f and IF/ID for exactly K edges. No instruction is lost or duplicated.
- **Input sampling:** stall_f, flush_d and redirect_en are level inputs sampled at each rising edge. There is no handshake.

## Configuration
- **Macro:** FETCH_PERF_CNT_EN.
- **Defined:**
  - fetch_cnt increments on every edge that performs a Capture.
  - bubble_cnt increments on every edge that performs a Flush or Stall.
  - Both counters wrap modulo 2^DATA_WIDTH and are cleared only by rst.
- **Undefined:** no counter registers are synthesised and both ports are tied to 0. The port list is identical in both builds.

## Structure
- **Shared package (core-wide):**
  - `NOP_INSTR` and `RESET_PC` defaults.
  - Packed struct for the IF/ID register (instr, pc, pc_plus4, valid), reused by decode.
- **Sub-module:** `fetch_perf_cnt` holds the two counters, instantiated only under FETCH_PERF_CNT_EN.
- Next-PC mux, PC register and IF/ID register stay in fetch_unit.

## Test plan
- **Reset:** assert rst for 3 cycles mid-run, release.
  - During reset: pc_f=0, valid_d=0, instr_d=32'h13.
  - After release: pc_f steps 0,4,8 on successive edges.
- **Sequential fetch:** memory at word addresses 0..3 holds 32'hA0..A3. After 4 edges from reset, instr_d shows A0..A3 with pc_d 0,4,8,C and pc_plus4_d 4,8,C,10, valid_d=1.
- **Stall:** stall_f high 2 cycles while pc_f=8. pc_f stays 8 and instr_d holds A1 for 2 cycles. Then A2 follows with no duplicate or skip.
- **Redirect:** redirect_en with target 32'h43 at pc_f=C.
  - Next cycle: pc_f=40, valid_d=0.
  - Cycle after: instr_d=mem[40], pc_d=40.
- **Redirect during stall:** stall_f=1 and redirect_en=1 (target 20) together. Next cycle pc_f=20 and valid_d=0. With FETCH_PERF_CNT_EN defined, bubble_cnt increments by 1.
- **Wrap and flush:** redirect to FFFF_FFFC, then run one edge so pc_f=0. Then assert flush_d alone for one cycle. Required: pc_f advances 4, valid_d=0, instr_d=32'h13.
